uart_rx_apb_writer: RTL

Receive-side counterpart of the encrypted APB-to-UART transmit path. An oversampled UART receiver deserializes 8N1 frames from the serial line. Every 4 bytes are packed into a 32-bit word and buffered in a word FIFO. An APB master drains the FIFO by issuing write transfers to incrementing addresses in an APB register-file slave, starting from a programmable base address.

---
 rtl/uart_rx_apb_writer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_apb_writer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_apb_writer
// Description : Oversampled 8N1 UART receiver that packs every 4 bytes into a
//               32-bit word, buffers the words in a first-word-fall-through
//               FIFO, and drains them as APB writes to incrementing addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_apb_writer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NBYTES      = DATA_WIDTH / 8,
  parameter int NTICKS      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  rx,
  input  logic [10:0]           divisor,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [NBYTES-1:0]     PSTRB,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  output logic                  blk_done,
  output logic                  frame_err,
  output logic                  overflow,
  output logic                  busy
);

  localparam int TW  = $clog2(NTICKS);
  localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {AP_IDLE, AP_SETUP, AP_ACCESS} apb_state_t;

  logic                  rx_meta, rx_sync;
  logic [10:0]           div_cnt, div_eff;
  logic                  tick;
  rx_state_t             rx_state, rx_next;
  logic [TW-1:0]         tcnt, tcnt_next;
  logic [2:0]            bcnt, bcnt_next;
  logic [7:0]            sh, sh_next;
  logic                  byte_ok, stop_bad;
  logic [BCW-1:0]        byte_cnt, slot;
  logic [DATA_WIDTH-1:0] word_buf, word_in;
  logic                  start_ok, word_full, push, pop;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  empty, full;
  apb_state_t            apb_state, apb_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [WCW-1:0]        word_cnt;

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Free-running oversample tick generator; divisor 0 behaves as 1
  assign div_eff = (divisor == 11'd0) ? 11'd1 : divisor;
  assign tick    = (div_cnt >= div_eff - 11'd1);
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 11'd1;
  end

  // RX state and bit-timing registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_state <= RX_IDLE;
      tcnt     <= '0;
      bcnt     <= '0;
      sh       <= '0;
    end else begin
      rx_state <= rx_next;
      tcnt     <= tcnt_next;
      bcnt     <= bcnt_next;
      sh       <= sh_next;
    end
  end

  // RX next-state: half-bit start check, mid-bit data samples, stop check
  always_comb begin
    rx_next   = rx_state;
    tcnt_next = tcnt;
    bcnt_next = bcnt;
    sh_next   = sh;
    byte_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_next   = RX_START;
          tcnt_next = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (tcnt == TW'(NTICKS / 2 - 1)) begin
            tcnt_next = '0;
            bcnt_next = '0;
            rx_next   = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            tcnt_next = tcnt + TW'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tcnt == TW'(NTICKS - 1)) begin
            tcnt_next = '0;
            sh_next   = {rx_sync, sh[7:1]};
            if (bcnt == 3'd7) rx_next = RX_STOP;
            else              bcnt_next = bcnt + 3'd1;
          end else begin
            tcnt_next = tcnt + TW'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tcnt == TW'(NTICKS - 1)) begin
            tcnt_next = '0;
            rx_next   = RX_IDLE;
            byte_ok   = rx_sync;
            stop_bad  = !rx_sync;
          end else begin
            tcnt_next = tcnt + TW'(1);
          end
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // A honoured start redirects an arriving byte into slot 0
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(FIFO_DEPTH));
  assign start_ok  = start && (apb_state == AP_IDLE) && empty;
  assign slot      = start_ok ? '0 : byte_cnt;
  assign word_full = byte_ok && (slot == BCW'(NBYTES - 1));
  assign push      = word_full && !full;
  assign pop       = (apb_state == AP_ACCESS) && PREADY;
  assign cnt_next  = cnt + CW'(push) - CW'(pop);

  // Merge the newly received byte into the partial word
  always_comb begin
    word_in = word_buf;
    word_in[8*slot +: 8] = sh;
  end

  // Byte packing, overflow flag and frame-error pulse
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      word_buf  <= '0;
      byte_cnt  <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (byte_ok) begin
        word_buf <= word_in;
        byte_cnt <= slot + BCW'(1);
      end else if (start_ok) begin
        byte_cnt <= '0;
      end
      if (start_ok)              overflow <= 1'b0;
      else if (word_full && full) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      cnt <= cnt_next;
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end
  end

  // APB state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) apb_state <= AP_IDLE;
    else          apb_state <= apb_next;
  end

  // APB next-state: back-to-back transfers when the FIFO stays non-empty
  always_comb begin
    apb_next = apb_state;
    case (apb_state)
      AP_IDLE:   if (!empty) apb_next = AP_SETUP;
      AP_SETUP:  apb_next = AP_ACCESS;
      AP_ACCESS: if (PREADY) apb_next = (cnt_next != '0) ? AP_SETUP : AP_IDLE;
      default:   apb_next = AP_IDLE;
    endcase
  end

  // Address pointer, block word counter and block-done pulse
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr      <= '0;
      word_cnt <= '0;
      blk_done <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      if (start_ok) begin
        ptr      <= start_addr;
        word_cnt <= '0;
      end else if (pop) begin
        ptr <= ptr + ADDR_WIDTH'(NBYTES);
        if (word_cnt == WCW'(BLOCK_WORDS - 1)) begin
          word_cnt <= '0;
          blk_done <= 1'b1;
        end else begin
          word_cnt <= word_cnt + WCW'(1);
        end
      end
    end
  end

  // APB outputs decode straight from state so reset drops PSELx at once
  assign PSELx   = (apb_state != AP_IDLE);
  assign PENABLE = (apb_state == AP_ACCESS);
  assign PWRITE  = PSELx;
  assign PSTRB   = {NBYTES{PSELx}};
  assign PADDR   = PSELx ? ptr : '0;
  assign PWDATA  = PSELx ? mem[rd_ptr] : '0;
  assign busy    = PSELx || !empty;

endmodule
`default_nettype wire
